// File: rtl/trace_capture_unit_if.sv
// Dump port of the trace capture unit: oldest-first record stream with valid/ready.
interface trace_capture_unit_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32
);
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [DATA_W-1:0] rd_insc;
  logic [4:0]        rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_flags;

  modport master (output rd_valid, rd_pc, rd_insc, rd_reg, rd_data, rd_flags, input rd_ready);
  modport slave  (input rd_valid, rd_pc, rd_insc, rd_reg, rd_data, rd_flags, output rd_ready);
endinterface

// File: rtl/trace_capture_unit.sv
// Pre/post-trigger retire trace ring for the single-cycle MIPS core, dumped oldest-first.
// Optional TRACE_FILTER_EN adds cap_filter: capture only cycles that write a register or memory.
module trace_capture_unit #(
  parameter int PC_W     = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [PC_W-1:0]        trig_pc,
  input  logic [PC_W-1:0]        pc,
  input  logic [DATA_W-1:0]      insc,
  input  logic                   wea_reg,
  input  logic [4:0]             write_reg,
  input  logic [DATA_W-1:0]      r3_din,
  input  logic                   MemWrite,
`ifdef TRACE_FILTER_EN
  input  logic                   cap_filter,
`endif
  trace_capture_unit_if.master   rd,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int POST_EFF = (POST_CNT >= DEPTH) ? DEPTH - 1 : POST_CNT;

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, POST = 2'd2, DUMP = 2'd3} state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] insc;
    logic [4:0]        rg;
    logic [DATA_W-1:0] data;
    logic [1:0]        flags;
  } rec_t;

  state_t        st_q, st_d;
  rec_t          mem [DEPTH];
  rec_t          wr_rec, rd_rec;
  logic [AW-1:0] wr_ptr, rd_idx, post_q;
  logic          cap_ok, capture, trig_hit, restart, xfer;

`ifdef TRACE_FILTER_EN
  assign cap_ok = !cap_filter || wea_reg || MemWrite;
`else
  assign cap_ok = 1'b1;
`endif

  // arm wins over the trigger, and is only honoured before the trigger fires
  assign restart  = arm && (st_q == IDLE || st_q == PRE);
  assign trig_hit = (st_q == PRE) && !arm && trig_en && (pc == trig_pc);
  assign capture  = (((st_q == PRE) && !arm) || (st_q == POST)) && cap_ok;
  assign xfer     = rd.rd_valid && rd.rd_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (arm) st_d = PRE;
      PRE:  if (trig_hit) st_d = (POST_EFF == 0) ? DUMP : POST;
      POST: if (capture && post_q == AW'(1)) st_d = DUMP;
      DUMP: if (count == '0 || (xfer && count == CW'(1))) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_q   <= '0;
    end else if (restart) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count == CW'(DEPTH)) overflow <= 1'b1;
        else                     count    <= count + CW'(1);
      end
      if (trig_hit)                        post_q <= AW'(POST_EFF);
      else if (capture && st_q == POST)    post_q <= post_q - AW'(1);
      if (xfer) count <= count - CW'(1);
    end
  end

  assign wr_rec = {pc, insc, write_reg, r3_din, MemWrite, wea_reg};

  always_ff @(posedge clk)
    if (capture) mem[wr_ptr] <= wr_rec;

  // oldest entry sits count slots behind the write pointer; a full ring wraps to wr_ptr itself
  assign rd_idx = wr_ptr - count[AW-1:0];
  assign rd_rec = mem[rd_idx];

  assign rd.rd_valid = (st_q == DUMP) && (count != '0);
  assign rd.rd_pc    = rd.rd_valid ? rd_rec.pc    : '0;
  assign rd.rd_insc  = rd.rd_valid ? rd_rec.insc  : '0;
  assign rd.rd_reg   = rd.rd_valid ? rd_rec.rg    : '0;
  assign rd.rd_data  = rd.rd_valid ? rd_rec.data  : '0;
  assign rd.rd_flags = rd.rd_valid ? rd_rec.flags : '0;
  assign state       = st_q;
endmodule

// File: tb/tb_trace_capture_unit.sv
// Randomised bench for trace_capture_unit: queue-based trace model plus dump scoreboard.
module tb_trace_capture_unit;
  localparam int PC_W = 8, DATA_W = 32, DEPTH = 16, POST_CNT = 8;
  localparam int PE = (POST_CNT >= DEPTH) ? DEPTH - 1 : POST_CNT;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] insc;
    logic [4:0]        rg;
    logic [DATA_W-1:0] data;
    logic              mw;
    logic              wea;
  } rec_t;

  logic clk, rst_n, arm, trig_en, wea_reg, MemWrite, cap_filter;
  logic [PC_W-1:0] trig_pc, pc;
  logic [DATA_W-1:0] insc, r3_din;
  logic [4:0] write_reg;
  logic [1:0] state;
  logic [$clog2(DEPTH):0] count;
  logic overflow;

  trace_capture_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) rdi ();

  trace_capture_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .POST_CNT(POST_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .pc(pc), .insc(insc), .wea_reg(wea_reg), .write_reg(write_reg), .r3_din(r3_din),
    .MemWrite(MemWrite),
`ifdef TRACE_FILTER_EN
    .cap_filter(cap_filter),
`endif
    .rd(rdi), .state(state), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  rec_t exp_q[$];
  rec_t m_q[$];
  int   m_state = 0, m_post = 0;
  bit   m_ovf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Model: the ring is just the last DEPTH captured records
  task automatic m_cap();
    rec_t r;
    r = '{pc: pc, insc: insc, rg: write_reg, data: r3_din, mw: MemWrite, wea: wea_reg};
    m_q.push_back(r);
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_ovf = 1;
    end
  endtask

  task automatic m_dump();
    m_state = 3;
    foreach (m_q[i]) exp_q.push_back(m_q[i]);
  endtask

  task automatic model_step();
    bit keep;
    keep = 1;
`ifdef TRACE_FILTER_EN
    keep = !cap_filter || wea_reg || MemWrite;
`endif
    if (!rst_n) begin
      m_state = 0; m_q.delete(); m_ovf = 0; exp_q.delete();
    end else case (m_state)
      0: if (arm) begin m_q.delete(); m_ovf = 0; m_state = 1; end
      1: if (arm) begin m_q.delete(); m_ovf = 0; end
         else begin
           if (keep) m_cap();
           if (trig_en && pc == trig_pc) begin
             m_post = PE;
             if (m_post == 0) m_dump(); else m_state = 2;
           end
         end
      2: if (keep) begin
           m_cap();
           m_post--;
           if (m_post == 0) m_dump();
         end
      default: begin
        if (m_q.size() != 0 && rdi.rd_ready) void'(m_q.pop_front());
        if (m_q.size() == 0) m_state = 0;
      end
    endcase
  endtask

  task automatic check_all();
    bit v;
    v = (m_state == 3) && (m_q.size() != 0);
    chk("state", 64'(state), 64'(m_state));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rd_valid", 64'(rdi.rd_valid), 64'(v));
    if (!v) begin
      chk("idle_rd_pc", 64'(rdi.rd_pc), 64'd0);
      chk("idle_rd_data", 64'(rdi.rd_data), 64'd0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cyc(input bit a, input bit rdy);
    arm = a;
    rdi.rd_ready = rdy;
    insc = $urandom; r3_din = $urandom; write_reg = 5'($urandom);
    wea_reg = 1'($urandom); MemWrite = 1'($urandom);
    cap_filter = 1'($urandom);
    tick();
    pc = pc + 8'd4;
  endtask

  task automatic start(input logic [PC_W-1:0] tp);
    trig_en = 1; trig_pc = tp; pc = 8'hFC;
    cyc(1, 1);
  endtask

  // rmode: 1 = always ready, 0 = random ready; arm_p: 1-in-N random arm pulses (0 = none)
  task automatic run_until(input int target, input int maxc, input bit rmode, input int arm_p);
    int n;
    n = 0;
    while (m_state != target && n < maxc) begin
      cyc((arm_p != 0) && ($urandom_range(0, arm_p - 1) == 0),
          rmode ? 1'b1 : 1'($urandom));
      n++;
    end
    total++;
    if (m_state != target) begin
      bad++;
      $display("FAIL timeout waiting for state %0d", target);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rdi.rd_valid), 64'd0);
    for (int i = 0; i < n; i++) cyc(1'($urandom), 1'($urandom));
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rdi.rd_valid && rdi.rd_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_xfer rd_pc=%0h want=none", rdi.rd_pc);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rd_pc", 64'(rdi.rd_pc), 64'(e.pc));
        chk("rd_insc", 64'(rdi.rd_insc), 64'(e.insc));
        chk("rd_reg", 64'(rdi.rd_reg), 64'(e.rg));
        chk("rd_data", 64'(rdi.rd_data), 64'(e.data));
        chk("rd_flags", 64'(rdi.rd_flags), 64'({e.mw, e.wea}));
      end
    end
  end

  initial begin
    rst_n = 0; arm = 0; trig_en = 0; trig_pc = '0; pc = '0; insc = '0;
    wea_reg = 0; write_reg = '0; r3_din = '0; MemWrite = 0; cap_filter = 0;
    rdi.rd_ready = 0;
    #2;
    do_reset(3);

    // basic trigger: records 0x00..0x30
    start(8'h10);
    run_until(0, 100, 1, 0);
    chk("drain_basic", 64'(exp_q.size()), 64'd0);

    // deep pre-trigger history wraps the ring: records 0x64..0xA0
    start(8'h80);
    run_until(0, 200, 1, 0);
    chk("drain_ovf", 64'(exp_q.size()), 64'd0);

    // backpressure: oldest record must hold while rd_ready is low
    start(8'h10);
    run_until(3, 100, 1, 0);
    cyc(0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0);
      chk("hold_rd_pc", 64'(rdi.rd_pc), 64'(exp_q[0].pc));
      chk("hold_rd_insc", 64'(rdi.rd_insc), 64'(exp_q[0].insc));
      chk("hold_rd_data", 64'(rdi.rd_data), 64'(exp_q[0].data));
    end
    run_until(0, 100, 1, 0);
    chk("drain_bp", 64'(exp_q.size()), 64'd0);

    // reset after three transfers, then a clean recapture
    start(8'h10);
    run_until(3, 100, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1);
    do_reset(2);
    start(8'h20);
    run_until(0, 100, 1, 0);
    chk("drain_rst", 64'(exp_q.size()), 64'd0);

    // no trigger: ring saturates, then re-arm inside PRE
    trig_en = 0; pc = 8'hFC;
    cyc(1, 1);
    for (int i = 0; i < 40; i++) cyc(0, 1);
    cyc(1, 1);
    trig_en = 1; trig_pc = pc + 8'd24;
    run_until(0, 100, 1, 0);
    chk("drain_rearm", 64'(exp_q.size()), 64'd0);

    // random triggers, random arm pulses and random backpressure
    for (int k = 0; k < 8; k++) begin
      start(8'h00);
      trig_pc = pc + 8'(4 * $urandom_range(1, 40));
      run_until(0, 600, 0, 12);
      chk("drain_rand", 64'(exp_q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
